// File: rtl/board_link_tx_scheduler.sv
// ---------------------------------------------------------------------------
// board_link_tx_scheduler
// Master-board scheduler for the shared 4-bit cross-board code link that
// feeds the slave LED decoder. Requesters are arbitrated round-robin. Each
// accepted code is held for HOLD_CYCLES so the slave's input synchroniser
// captures it cleanly, and it is always followed by idle code 15. The link
// therefore only ever moves between 15 and a code, never from one code
// straight to another. Boss-scene mode pre-empts requesters and drives
// code 14 for as long as it stays asserted.
// ---------------------------------------------------------------------------
module board_link_tx_scheduler #(
   parameter int N_REQ       = 4,  // number of requesters (2..8)
   parameter int HOLD_CYCLES = 8,  // cycles each code is held (>=4)
   parameter int GAP_CYCLES  = 4   // idle-15 cycles after each code or boss exit (>=1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [4*N_REQ-1:0]   req_code,
   input  logic                 boss_mode,
   output logic [N_REQ-1:0]     grant,
   output logic                 err,
   output logic [3:0]           data_out,
   output logic                 busy
);

   localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PTR_W   = $clog2(N_REQ);

   localparam logic [3:0] CODE_IDLE = 4'd15;
   localparam logic [3:0] CODE_BOSS = 4'd14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      BOSS = 2'd3
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_next;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     rr_next;
   logic [3:0]           data_next;
   logic [N_REQ-1:0]     grant_next;
   logic                 err_next;

   // Arbiter results
   logic                 found;
   logic [PTR_W-1:0]     winner;
   logic [3:0]           win_code;
   logic [PTR_W-1:0]     rr_after;

   // Round-robin search: first set request at or above rr_ptr, wrapping mod N_REQ.
   always_comb begin
      logic [PTR_W:0] idx;
      // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int off = 0; off < N_REQ; off++) begin
         idx = {1'b0, rr_ptr} + (PTR_W+1)'(off);
         if (idx >= (PTR_W+1)'(N_REQ)) begin
            idx = idx - (PTR_W+1)'(N_REQ);
         end
         if (!found && req[idx[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[PTR_W-1:0];
         end
      end
   end

   // Code of the winning requester and the pointer value that follows it.
   always_comb begin
      win_code = req_code[{winner, 2'b00} +: 4];
      rr_after = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
   end

   // Next-state and next-output decode; every registered output is computed here.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      rr_next    = rr_ptr;
      data_next  = data_out;
      grant_next = '0;
      err_next   = 1'b0;

      unique case (state)
         IDLE: begin
            data_next = CODE_IDLE;
            if (boss_mode) begin
               // Boss scene outranks any pending request; requests wait, none are lost.
               state_next = BOSS;
               data_next  = CODE_BOSS;
            end else if (found) begin
               grant_next[winner] = 1'b1;
               rr_next            = rr_after;
               cnt_next           = CNT_W'(1);
               if (win_code >= CODE_BOSS) begin
                  // Reserved codes would be misread by the slave: drop and flag.
                  err_next   = 1'b1;
                  state_next = GAP;
               end else begin
                  state_next = SEND;
                  data_next  = win_code;
               end
            end
         end

         SEND: begin
            // Code is never truncated: boss_mode and new requests wait for the hold to end.
            if (cnt == CNT_W'(HOLD_CYCLES)) begin
               state_next = GAP;
               data_next  = CODE_IDLE;
               cnt_next   = CNT_W'(1);
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end

         GAP: begin
            data_next = CODE_IDLE;
            if (cnt == CNT_W'(GAP_CYCLES)) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end

         BOSS: begin
            data_next = CODE_BOSS;
            if (!boss_mode) begin
               state_next = GAP;
               data_next  = CODE_IDLE;
               cnt_next   = CNT_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
            data_next  = CODE_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // State, counter, pointer and all link outputs are registered together.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rr_ptr   <= '0;
         data_out <= CODE_IDLE;
         grant    <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         rr_ptr   <= rr_next;
         data_out <= data_next;
         grant    <= grant_next;
         err      <= err_next;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_board_link_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_board_link_tx_scheduler
// Directed bench for the cross-board link scheduler (N_REQ=4, HOLD=8, GAP=4).
// Inputs change and outputs are sampled just after the falling clock edge.
// ---------------------------------------------------------------------------
module tb_board_link_tx_scheduler;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_code;
   logic        boss_mode;
   logic [3:0]  grant;
   logic        err;
   logic [3:0]  data_out;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   board_link_tx_scheduler #(
      .N_REQ       (4),
      .HOLD_CYCLES (8),
      .GAP_CYCLES  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_code  (req_code),
      .boss_mode (boss_mode),
      .grant     (grant),
      .err       (err),
      .data_out  (data_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; afterwards outputs reflect the rising edge just passed.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req       = '0;
      req_code  = '0;
      boss_mode = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Step until a grant appears or the budget runs out.
   task automatic wait_grant(input int budget, output int waited);
      waited = 0;
      while (grant == 4'b0000 && waited < budget) begin
         step();
         waited++;
      end
   endtask

   // Count consecutive cycles with data_out == val, starting at the current sample.
   task automatic count_run(input logic [3:0] val, input int max, output int n);
      n = 0;
      while (data_out == val && n < max) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (data_out !== 4'd15) begin
         n_fail++; $display("FAIL reset_data: got %0d want 15", data_out);
      end
      n_cmp++;
      if (busy !== 1'b0 || grant !== 4'b0000 || err !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: busy=%b grant=%b err=%b want 0 0000 0", busy, grant, err);
      end
      for (int c = 0; c < 20; c++) begin
         step();
         n_cmp++;
         if (data_out !== 4'd15 || busy !== 1'b0 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_cycle%0d: data=%0d busy=%b grant=%b want 15 0 0000", c, data_out, busy, grant);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      req      = 4'b0100;
      req_code = 16'h0500;
      step();
      n_cmp++;
      if (grant !== 4'b0100 || data_out !== 4'd5 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_grant: grant=%b data=%0d busy=%b want 0100 5 1", grant, data_out, busy);
      end
      req = '0;
      for (int c = 1; c < 8; c++) begin
         step();
         n_cmp++;
         if (data_out !== 4'd5 || grant !== 4'b0000) begin
            n_fail++; $display("FAIL single_hold%0d: data=%0d grant=%b want 5 0000", c, data_out, grant);
         end
      end
      for (int c = 0; c < 4; c++) begin
         step();
         n_cmp++;
         if (data_out !== 4'd15 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_gap%0d: data=%0d busy=%b want 15 1", c, data_out, busy);
         end
      end
      step();
      n_cmp++;
      if (data_out !== 4'd15 || busy !== 1'b0) begin
         n_fail++; $display("FAIL single_idle: data=%0d busy=%b want 15 0", data_out, busy);
      end
   endtask

   task automatic test_round_robin();
      int w;
      int n;
      logic [3:0] exp_g;
      logic [3:0] exp_d;
      do_reset();
      req      = 4'b1111;
      req_code = 16'h4321;
      step();
      for (int i = 0; i < 4; i++) begin
         exp_g = 4'(1 << i);
         exp_d = 4'(i + 1);
         wait_grant(30, w);
         n_cmp++;
         if (grant !== exp_g || data_out !== exp_d) begin
            n_fail++; $display("FAIL rr_grant%0d: grant=%b data=%0d want %b %0d", i, grant, data_out, exp_g, exp_d);
         end
         req[i] = 1'b0;
         if (i == 3) req = 4'b1001;  // re-assert: pointer has wrapped to 0
         count_run(exp_d, 20, n);
         n_cmp++;
         if (n !== 8) begin
            n_fail++; $display("FAIL rr_hold%0d: got %0d cycles want 8", i, n);
         end
         count_run(4'd15, 20, n);
         n_cmp++;
         if (n !== 5) begin
            n_fail++; $display("FAIL rr_gap%0d: got %0d cycles want 5", i, n);
         end
      end
      wait_grant(30, w);
      n_cmp++;
      if (grant !== 4'b0001 || data_out !== 4'd1) begin
         n_fail++; $display("FAIL rr_wrap: grant=%b data=%0d want 0001 1", grant, data_out);
      end
      req = '0;
   endtask

   task automatic test_boss();
      int n;
      int w;
      do_reset();
      req      = 4'b0001;
      req_code = 16'h0097;
      step();
      n_cmp++;
      if (grant !== 4'b0001 || data_out !== 4'd7) begin
         n_fail++; $display("FAIL boss_first_grant: grant=%b data=%0d want 0001 7", grant, data_out);
      end
      req       = 4'b0010;
      boss_mode = 1'b1;
      count_run(4'd7, 20, n);
      n_cmp++;
      if (n !== 8) begin
         n_fail++; $display("FAIL boss_code_hold: got %0d cycles want 8", n);
      end
      count_run(4'd15, 20, n);
      n_cmp++;
      if (n !== 5) begin
         n_fail++; $display("FAIL boss_pre_gap: got %0d cycles want 5", n);
      end
      for (int c = 0; c < 6; c++) begin
         n_cmp++;
         if (data_out !== 4'd14 || grant !== 4'b0000 || busy !== 1'b1) begin
            n_fail++; $display("FAIL boss_hold%0d: data=%0d grant=%b busy=%b want 14 0000 1", c, data_out, grant, busy);
         end
         step();
      end
      boss_mode = 1'b0;
      step();
      count_run(4'd15, 20, n);
      n_cmp++;
      if (n !== 5) begin
         n_fail++; $display("FAIL boss_exit_gap: got %0d cycles want 5", n);
      end
      wait_grant(10, w);
      n_cmp++;
      if (grant !== 4'b0010 || data_out !== 4'd9) begin
         n_fail++; $display("FAIL boss_pending: grant=%b data=%0d want 0010 9", grant, data_out);
      end
      req = '0;
   endtask

   task automatic test_err();
      do_reset();
      req      = 4'b1000;
      req_code = 16'hE000;
      step();
      n_cmp++;
      if (grant !== 4'b1000 || err !== 1'b1 || data_out !== 4'd15 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL err14_pulse: grant=%b err=%b data=%0d busy=%b want 1000 1 15 1", grant, err, data_out, busy);
      end
      req = '0;
      step();
      n_cmp++;
      if (grant !== 4'b0000 || err !== 1'b0 || data_out !== 4'd15) begin
         n_fail++; $display("FAIL err14_clear: grant=%b err=%b data=%0d want 0000 0 15", grant, err, data_out);
      end
      step();
      step();
      n_cmp++;
      if (busy !== 1'b1 || data_out !== 4'd15) begin
         n_fail++; $display("FAIL err14_gap_end: busy=%b data=%0d want 1 15", busy, data_out);
      end
      step();
      n_cmp++;
      if (busy !== 1'b0 || data_out !== 4'd15) begin
         n_fail++; $display("FAIL err14_idle: busy=%b data=%0d want 0 15", busy, data_out);
      end
      // Pointer wrapped from 3 to 0; code 15 on requester 0 is also reserved.
      req      = 4'b1001;
      req_code = 16'h100F;
      step();
      n_cmp++;
      if (grant !== 4'b0001 || err !== 1'b1 || data_out !== 4'd15) begin
         n_fail++; $display("FAIL err15_pulse: grant=%b err=%b data=%0d want 0001 1 15", grant, err, data_out);
      end
      req = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req      = 4'b0100;
      req_code = 16'h0600;
      step();
      n_cmp++;
      if (grant !== 4'b0100 || data_out !== 4'd6) begin
         n_fail++; $display("FAIL mid_grant: grant=%b data=%0d want 0100 6", grant, data_out);
      end
      req = '0;
      step();
      step();
      rst      = 1'b1;
      req      = 4'b1010;
      req_code = 16'h3020;
      step();
      n_cmp++;
      if (data_out !== 4'd15 || busy !== 1'b0 || grant !== 4'b0000 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: data=%0d busy=%b grant=%b err=%b want 15 0 0000 0", data_out, busy, grant, err);
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (grant !== 4'b0010 || data_out !== 4'd2) begin
         n_fail++; $display("FAIL mid_ptr_cleared: grant=%b data=%0d want 0010 2", grant, data_out);
      end
      req = '0;
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      req_code  = '0;
      boss_mode = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_boss();
      test_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
